// File: rtl/core_prefetch_buffer.sv
// rtl/core_prefetch_buffer.sv - instruction prefetch: sequential fetch issue, in-flight tracking, PC-tagged FIFO
// Redirects empty the FIFO and drop the responses still in flight.
module core_prefetch_buffer #(
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int ADDR_W          = 32,
    parameter int DATA_W          = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] boot_addr_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_addr_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_grnt_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i,
    output logic              fetch_valid_o,
    output logic [DATA_W-1:0] fetch_instr_o,
    output logic [ADDR_W-1:0] fetch_addr_o,
    input  logic              fetch_ready_i
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = ((CW > OW) ? CW : OW) + 1;

    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [OW-1:0]     outstanding_q, outstanding_d;
    logic [OW-1:0]     discard_q, discard_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [DATA_W-1:0] instr_mem_q [DEPTH];
    logic [ADDR_W-1:0] pc_mem_q    [DEPTH];

    logic          credit;
    logic          grant;
    logic          push;
    logic          pop;
    logic [SW-1:0] reserved;

    // Every in-flight request already owns a FIFO slot, so a response can always be pushed.
    always_comb begin
        reserved  = SW'(count_q) + SW'(outstanding_q);
        credit    = (outstanding_q < OW'(MAX_OUTSTANDING)) && (reserved < SW'(DEPTH));
        mem_req_o = !rst_i && !flush_i && credit;
        grant     = mem_req_o && mem_grnt_i;
        push      = !flush_i && mem_rvalid_i && (discard_q == '0);
        pop       = !flush_i && (count_q != '0) && fetch_ready_i;
    end

    always_comb begin
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;
        discard_d     = discard_q;
        count_d       = count_q;
        wptr_d        = wptr_q;
        rptr_d        = rptr_q;
        outstanding_d = outstanding_q + OW'(grant) - OW'(mem_rvalid_i);
        if (flush_i) begin
            req_pc_d  = flush_addr_i;
            rsp_pc_d  = flush_addr_i;
            discard_d = outstanding_q - OW'(mem_rvalid_i);
            count_d   = '0;
            wptr_d    = '0;
            rptr_d    = '0;
        end else begin
            if (grant) begin
                req_pc_d = req_pc_q + ADDR_W'(4);
            end
            if (mem_rvalid_i) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - OW'(1);
                end else begin
                    rsp_pc_d = rsp_pc_q + ADDR_W'(4);
                end
            end
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_pc_q      <= boot_addr_i;
            rsp_pc_q      <= boot_addr_i;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            instr_mem_q[wptr_q] <= mem_rdata_i;
            pc_mem_q[wptr_q]    <= rsp_pc_q;
        end
    end

    always_comb begin
        mem_addr_o    = req_pc_q;
        fetch_valid_o = !rst_i && (count_q != '0);
        fetch_instr_o = rst_i ? '0 : instr_mem_q[rptr_q];
        fetch_addr_o  = rst_i ? '0 : pc_mem_q[rptr_q];
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (count_q == CW'(DEPTH))));

endmodule

// File: doc/core_prefetch_buffer.md
Name: core_prefetch_buffer

Overview:
- Instruction prefetch stage between the instruction memory bus and core fetch.
- Issues sequential word fetches ahead of the core and tracks up to MAX_OUTSTANDING in-flight requests.
- Buffers returned instructions with their PCs in a DEPTH-entry FIFO.
- On redirect (branch/exception), empties the FIFO, restarts at the new address, and silently drops responses still in flight.

Parameters:
DEPTH, 4, FIFO entries (power of two, >=2)
MAX_OUTSTANDING, 2, max granted-but-unanswered memory requests (>=1)
ADDR_W, 32, address width
DATA_W, 32, instruction width

Ports:
clk_i  in  1  clock, all state on rising edge
rst_i  in  1  synchronous reset, active-high
boot_addr_i  in  ADDR_W  first fetch address after reset
flush_i  in  1  redirect request
flush_addr_i  in  ADDR_W  redirect target, word aligned
mem_req_o  out  1  fetch request to instruction memory
mem_addr_o  out  ADDR_W  fetch address
mem_grnt_i  in  1  request accepted this cycle
mem_rdata_i  in  DATA_W  response data
mem_rvalid_i  in  1  response valid; in order; at least 1 cycle after its grant
fetch_valid_o  out  1  FIFO head valid
fetch_instr_o  out  DATA_W  FIFO head instruction
fetch_addr_o  out  ADDR_W  PC of FIFO head
fetch_ready_i  in  1  core consumes head when valid and ready

Behaviour:

Reset (rst_i=1 at a clock edge):
- Effects: req_pc<=boot_addr_i; rsp_pc<=boot_addr_i; FIFO empty; outstanding=0; discard=0.
- Outputs while rst_i=1: mem_req_o=0, fetch_valid_o=0. fetch_instr_o and fetch_addr_o are don't-care but drive 0.
- Reset mid-operation aborts everything.
- mem_rvalid_i seen while rst_i=1 is ignored.
- Responses to pre-reset grants are the memory's responsibility (the bench must not send them).

Request side:
- Credit test: outstanding < MAX_OUTSTANDING AND (fifo_count + outstanding) < DEPTH.
- mem_req_o = !rst_i & !flush_i & credit. It is combinational from registered state and flush_i.
- mem_addr_o = req_pc.
- Grant is counted only when mem_req_o & mem_grnt_i. Then req_pc+=4 (wraps modulo 2^ADDR_W) and outstanding+1.
- While mem_req_o=1 without grant, mem_addr_o is held stable.
- Only flush_i or rst_i may withdraw a pending request.

Response side:
- outstanding-1 on every mem_rvalid_i; +1/-1 in the same cycle nets 0.
- If discard>0: the response is dropped and discard-1.
- Otherwise: push {mem_rdata_i, rsp_pc}, then rsp_pc+=4.
- Push cannot overflow because of credit reservation. An assertion flags push when full.
- Latency: rvalid at cycle N gives fetch_valid_o at N+1. There is no bypass.
- First request appears in the cycle after reset deasserts (credit available).

Consumer side:
- fetch_valid_o = fifo_count!=0.
- Head fields are registered FIFO outputs.
- Pop on fetch_valid_o & fetch_ready_i.
- Push and pop in the same cycle: count unchanged, order preserved. This is legal when full only if a pop occurs.

Flush (flush_i=1 at an edge):
- Effects: FIFO emptied; req_pc<=flush_addr_i; rsp_pc<=flush_addr_i; discard<=outstanding - (mem_rvalid_i?1:0).
- Any response arriving in the flush cycle is dropped. outstanding still decrements for it.
- Pop in the flush cycle is ignored.
- mem_req_o=0 in the flush cycle, so no new grant.
- Back-to-back flushes: the last target wins, and discard recomputes from current outstanding.
- Precedence: rst_i > flush_i > grant/response/pop.

Counter widths:
- outstanding and discard: clog2(MAX_OUTSTANDING+1) bits.
- fifo_count: clog2(DEPTH+1) bits.
- FIFO pointers are clog2(DEPTH) bits and wrap naturally.

Test Plan:
1. Boot/stream: boot_addr_i=0x80, grant every cycle, rvalid 1 cycle after grant, ready=1. mem_addr_o sequence 0x80,0x84,0x88...; fetch_addr_o follows in order with matching data; at most 2 outstanding.
2. Backpressure: fetch_ready_i=0, responses immediate. Exactly 4 grants occur; mem_req_o drops to 0 and fetch_valid_o stays 1 with head PC 0x80. Raising ready resumes requests within 1 cycle of the first pop.
3. Stall without grant: mem_grnt_i=0 for 5 cycles. mem_req_o=1 and mem_addr_o constant throughout; grant on cycle 6 advances the address by 4.
4. Flush with 2 outstanding: flush_i=1, flush_addr_i=0x200, one rvalid in the flush cycle. Both old responses are dropped, FIFO empties, next mem_addr_o=0x200, and the first fetch_addr_o is 0x200.
5. Simultaneous push/pop at count=3 with credit gating. Count stays 3 and ordering is intact. Flush plus pop in the same cycle gives FIFO empty the next cycle.
6. Reset mid-stream with FIFO holding 3 entries: rst_i=1 for 1 cycle. fetch_valid_o=0 and mem_req_o=0 during reset; afterwards fetching restarts at boot_addr_i.
